and2_arb_ctrl: RTL and testbench

AND2_ARB_CTRL -- requirements
Module: and2_arb_ctrl

---
 rtl/and2_arb_ctrl.sv | 80 ++++++++
 tb/tb_and2_arb_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/and2_arb_ctrl.sv
// rtl/and2_arb_ctrl.sv - 4-requester round-robin arbiter over one shared AND datapath, 1-slot response
// Optional per-requester grant counters: define AND2_ARB_CTRL_STATS_EN
module and2_arb_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req_valid,
   input  logic [4*WIDTH-1:0] req_a,
   input  logic [4*WIDTH-1:0] req_b,
   output logic [3:0]         req_ready,
   output logic               rsp_valid,
   output logic [1:0]         rsp_id,
   output logic [WIDTH-1:0]   rsp_y,
   input  logic               rsp_ready,
   output logic               busy
`ifdef AND2_ARB_CTRL_STATS_EN
   ,
   output logic [4*16-1:0]    grant_cnt
`endif
);

   logic [1:0]       last_grant;
   logic             slot_free;
   logic             gnt_found;
   logic [1:0]       gnt_idx;
   logic             transfer;
   logic [WIDTH-1:0] shared_y;

   assign slot_free = !rsp_valid || rsp_ready;

   // Search starts one past the last grant, so the pointer wraps 3 -> 0 naturally in 2 bits
   always_comb begin
      logic [1:0] cand;
      gnt_found = 1'b0;
      gnt_idx   = last_grant;
      cand      = last_grant;
      for (int k = 1; k <= 4; k++) begin
         cand = last_grant + 2'(k);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign req_ready = (!rst && slot_free && gnt_found) ? (4'b0001 << gnt_idx) : 4'b0000;
   assign transfer  = |req_ready;

   assign shared_y = req_a[gnt_idx*WIDTH +: WIDTH] & req_b[gnt_idx*WIDTH +: WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= 2'd0;
         rsp_y      <= '0;
         last_grant <= 2'd3;
      end else if (transfer) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= gnt_idx;
         rsp_y      <= shared_y;
         last_grant <= gnt_idx;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

   assign busy = rsp_valid;

`ifdef AND2_ARB_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= '0;
      end else if (transfer) begin
         grant_cnt[gnt_idx*16 +: 16] <= grant_cnt[gnt_idx*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_and2_arb_ctrl.sv
// tb/tb_and2_arb_ctrl.sv - self-checking bench for and2_arb_ctrl
module tb_and2_arb_ctrl;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         req_valid;
   logic [4*WIDTH-1:0] req_a;
   logic [4*WIDTH-1:0] req_b;
   logic [3:0]         req_ready;
   logic               rsp_valid;
   logic [1:0]         rsp_id;
   logic [WIDTH-1:0]   rsp_y;
   logic               rsp_ready;
   logic               busy;
`ifdef AND2_ARB_CTRL_STATS_EN
   logic [4*16-1:0]    grant_cnt;
`endif

   and2_arb_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_ready (rsp_ready),
      .busy      (busy)
`ifdef AND2_ARB_CTRL_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [31:0] a;
      logic [31:0] b;
      logic        rr;
      logic [3:0]  er;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [7:0] y;
   } rsp_t;

   vec_t tbl[12];
   rsp_t sbq[$];
   int   n_pass = 0;
   int   n_total = 0;
   logic m_full = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle; er is the hand-derived expected req_ready for this cycle
   task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                       input logic rr, input logic [3:0] er);
      rsp_t e;
      int   g;
      req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
      #3;
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, m_full);
      chk("busy", busy, m_full);
      if (m_full && rr) begin
         chk("sb_nonempty", sbq.size() != 0, 1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_y", rsp_y, e.y);
         end
      end
      if (er != 4'b0000) begin
         g = 0;
         for (int i = 0; i < 4; i++) if (er[i]) g = i;
         e.id = 2'(g);
         e.y  = a[g*8 +: 8] & b[g*8 +: 8];
         sbq.push_back(e);
         m_full = 1'b1;
      end else if (m_full && rr) begin
         m_full = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0]  = '{4'b0001, 32'h000000F0, 32'h0000003C, 1'b1, 4'b0001};
      tbl[1]  = '{4'b1111, $urandom, $urandom, 1'b1, 4'b0010};
      tbl[2]  = '{4'b1111, $urandom, $urandom, 1'b1, 4'b0100};
      tbl[3]  = '{4'b1111, $urandom, $urandom, 1'b1, 4'b1000};
      tbl[4]  = '{4'b1111, $urandom, $urandom, 1'b1, 4'b0001};
      tbl[5]  = '{4'b0000, $urandom, $urandom, 1'b1, 4'b0000};
      tbl[6]  = '{4'b0000, $urandom, $urandom, 1'b1, 4'b0000};
      tbl[7]  = '{4'b1000, $urandom, $urandom, 1'b1, 4'b1000};
      tbl[8]  = '{4'b0100, $urandom, $urandom, 1'b1, 4'b0100};
      tbl[9]  = '{4'b0011, $urandom, $urandom, 1'b1, 4'b0001};
      tbl[10] = '{4'b0000, $urandom, $urandom, 1'b1, 4'b0000};
      tbl[11] = '{4'b0000, $urandom, $urandom, 1'b1, 4'b0000};

      rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      @(posedge clk); #3;
      chk("ready_in_reset", req_ready, 4'b0000);
      @(posedge clk); #1;
      rst = 1'b0; req_valid = 4'b0000;
      #1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_id", rsp_id, 0);
      chk("reset_rsp_y", rsp_y, 0);
      chk("reset_busy", busy, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rr, tbl[i].er);
         if (i == 0) begin
            chk("single_rsp_id", rsp_id, 0);
            chk("single_rsp_y", rsp_y, 8'h30);
         end
      end

      // Backpressure: slot held with id 2, y 0x0A while requesters 0,1,3 wait
      step(4'b0100, 32'h000E0000, 32'h000B0000, 1'b0, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         step(4'b1011, $urandom, $urandom, 1'b0, 4'b0000);
         chk("bp_rsp_id", rsp_id, 2);
         chk("bp_rsp_y", rsp_y, 8'h0A);
      end
      step(4'b1011, $urandom, $urandom, 1'b1, 4'b1000);
      step(4'b0000, $urandom, $urandom, 1'b1, 4'b0000);
      step(4'b0000, $urandom, $urandom, 1'b1, 4'b0000);
      chk("sb_drained", sbq.size(), 0);

      // Reset mid-operation discards the held response
      step(4'b0001, 32'h000000FF, 32'h000000FF, 1'b0, 4'b0001);
      chk("pre_reset_y", rsp_y, 8'hFF);
      rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
      #3;
      chk("mid_reset_ready", req_ready, 4'b0000);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("post_reset_valid", rsp_valid, 0);
      chk("post_reset_y", rsp_y, 0);
      chk("post_reset_id", rsp_id, 0);
      sbq.delete();
      m_full = 1'b0;
      step(4'b1111, $urandom, $urandom, 1'b1, 4'b0001);
      step(4'b0000, $urandom, $urandom, 1'b1, 4'b0000);

`ifdef AND2_ARB_CTRL_STATS_EN
      rst = 1'b1; req_valid = 4'b0000;
      @(posedge clk); #1;
      rst = 1'b0;
      sbq.delete();
      m_full = 1'b0;
      chk("cnt_reset", grant_cnt, 64'd0);
      for (int i = 0; i < 3; i++) step(4'b0010, $urandom, $urandom, 1'b1, 4'b0010);
      step(4'b0000, $urandom, $urandom, 1'b1, 4'b0000);
      chk("cnt_three", grant_cnt, {16'd0, 16'd0, 16'd3, 16'd0});
      req_valid = 4'b0010; rsp_ready = 1'b1;
      repeat (65532) @(posedge clk);
      #1;
      chk("cnt_ffff", grant_cnt[31:16], 16'hFFFF);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      chk("cnt_wrap", grant_cnt, 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
